// File: rtl/cpu_req_dispatch_queue.sv
`default_nettype none
// ============================================================================
// Module      : cpu_req_dispatch_queue
// Description : In-order request FIFO between the CPU request port and a bank
//               of NUM_FSM control FSMs. The head entry goes to one idle FSM,
//               which is picked round-robin. An asserted fsm_valid bit means
//               the FSM has taken the entry in that cycle.
//               Optional macro CPU_REQ_DISPATCH_BYPASS_EN: when the queue is
//               empty, a request can be forwarded straight to an idle FSM in
//               the same cycle it arrives.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_req_dispatch_queue #(
    parameter int ADDR_W            = 10,
    parameter int CPU_OPCODE_W      = 2,
    parameter int ADDR_W_ENCODING_W = 3,
    parameter int DEPTH             = 4,
    parameter int NUM_FSM           = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [CPU_OPCODE_W-1:0]      in_opcode,
    input  logic [ADDR_W-1:0]            in_key_addr,
    input  logic [ADDR_W-1:0]            in_text_addr,
    input  logic [ADDR_W_ENCODING_W-1:0] in_text_width,
    input  logic [NUM_FSM-1:0]           fsm_ready,
    output logic [NUM_FSM-1:0]           fsm_valid,
    output logic [CPU_OPCODE_W-1:0]      out_opcode,
    output logic [ADDR_W-1:0]            out_key_addr,
    output logic [ADDR_W-1:0]            out_text_addr,
    output logic [ADDR_W_ENCODING_W-1:0] out_text_width,
    output logic [$clog2(DEPTH):0]       count
);

    localparam int c_PTR_W   = $clog2(DEPTH);
    localparam int c_CNT_W   = c_PTR_W + 1;
    localparam int c_RR_W    = (NUM_FSM > 1) ? $clog2(NUM_FSM) : 1;
    localparam int c_ENTRY_W = CPU_OPCODE_W + 2 * ADDR_W + ADDR_W_ENCODING_W;
    localparam logic [c_CNT_W-1:0] c_DEPTH    = c_CNT_W'(DEPTH);
    localparam logic [c_RR_W-1:0]  c_LAST_FSM = c_RR_W'(NUM_FSM - 1);

    logic [c_ENTRY_W-1:0] r_mem [DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_CNT_W-1:0]   r_count;
    logic [c_RR_W-1:0]    r_rr;

    logic [c_RR_W-1:0]    w_grant;
    logic                 w_any_ready;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_bypass;
    logic                 w_store;
    logic                 w_dispatch;
    logic [c_ENTRY_W-1:0] w_in_entry;

    assign w_any_ready = |fsm_ready;
    assign in_ready    = (r_count < c_DEPTH);
    assign count       = r_count;
    assign w_in_entry  = {in_opcode, in_key_addr, in_text_addr, in_text_width};
    assign w_push      = in_valid & in_ready;
    assign w_pop       = (r_count != '0) & w_any_ready;

`ifdef CPU_REQ_DISPATCH_BYPASS_EN
    // An empty queue hands the incoming request directly to an idle FSM.
    assign w_bypass = (r_count == '0) & in_valid & w_any_ready;
`else
    assign w_bypass = 1'b0;
`endif

    assign w_store    = w_push & ~w_bypass;
    assign w_dispatch = w_pop | w_bypass;

    // Round-robin search: the first ready FSM at or after r_rr, wrapping.
    // The scan runs backwards so the closest candidate is the last assignment.
    always_comb begin
        int idx;
        idx     = 0;
        w_grant = '0;
        for (int k = NUM_FSM - 1; k >= 0; k--) begin
            idx = (int'(r_rr) + k) % NUM_FSM;
            if (fsm_ready[idx]) begin
                w_grant = c_RR_W'(idx);
            end
        end
    end

    // One-hot valid to the granted FSM, only when there is something to hand over.
    always_comb begin
        fsm_valid = '0;
        if (w_dispatch) begin
            fsm_valid[w_grant] = 1'b1;
        end
    end

    // Head entry on the shared output bus. The bus is zero when the queue is empty,
    // unless a bypass is forwarding the request that is arriving.
    always_comb begin
        logic [c_ENTRY_W-1:0] entry;
        entry = '0;
        if (r_count != '0) begin
            entry = r_mem[r_rd_ptr];
        end else if (w_bypass) begin
            entry = w_in_entry;
        end
        {out_opcode, out_key_addr, out_text_addr, out_text_width} = entry;
    end

    // Storage array. Stale contents are never seen because the output is masked.
    always_ff @(posedge clk) begin
        if (w_store) begin
            r_mem[r_wr_ptr] <= w_in_entry;
        end
    end

    // Pointers, occupancy and round-robin state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_rr     <= '0;
        end else begin
            if (w_store) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_store, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_dispatch) begin
                r_rr <= (w_grant == c_LAST_FSM) ? '0 : (w_grant + 1'b1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cpu_req_dispatch_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_req_dispatch_queue
// Description : Directed bench for cpu_req_dispatch_queue. A queue-based
//               reference model is compared with the DUT on every cycle, and
//               literal expectations are checked at key points.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_req_dispatch_queue;

    localparam int ADDR_W            = 10;
    localparam int CPU_OPCODE_W      = 2;
    localparam int ADDR_W_ENCODING_W = 3;
    localparam int DEPTH             = 4;
    localparam int NUM_FSM           = 4;
    localparam int ENTRY_W           = CPU_OPCODE_W + 2 * ADDR_W + ADDR_W_ENCODING_W;

    logic                         clk = 1'b0;
    logic                         rst_n;
    logic                         in_valid;
    logic                         in_ready;
    logic [CPU_OPCODE_W-1:0]      in_opcode;
    logic [ADDR_W-1:0]            in_key_addr;
    logic [ADDR_W-1:0]            in_text_addr;
    logic [ADDR_W_ENCODING_W-1:0] in_text_width;
    logic [NUM_FSM-1:0]           fsm_ready;
    logic [NUM_FSM-1:0]           fsm_valid;
    logic [CPU_OPCODE_W-1:0]      out_opcode;
    logic [ADDR_W-1:0]            out_key_addr;
    logic [ADDR_W-1:0]            out_text_addr;
    logic [ADDR_W_ENCODING_W-1:0] out_text_width;
    logic [$clog2(DEPTH):0]       count;

    cpu_req_dispatch_queue #(
        .ADDR_W            (ADDR_W),
        .CPU_OPCODE_W      (CPU_OPCODE_W),
        .ADDR_W_ENCODING_W (ADDR_W_ENCODING_W),
        .DEPTH             (DEPTH),
        .NUM_FSM           (NUM_FSM)
    ) u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_opcode      (in_opcode),
        .in_key_addr    (in_key_addr),
        .in_text_addr   (in_text_addr),
        .in_text_width  (in_text_width),
        .fsm_ready      (fsm_ready),
        .fsm_valid      (fsm_valid),
        .out_opcode     (out_opcode),
        .out_key_addr   (out_key_addr),
        .out_text_addr  (out_text_addr),
        .out_text_width (out_text_width),
        .count          (count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [ENTRY_W-1:0] mq[$];
    int                 m_rr = 0;
    bit                 m_on = 1'b0;

    function automatic int m_grant();
        for (int k = 0; k < NUM_FSM; k++) begin
            if (fsm_ready[(m_rr + k) % NUM_FSM]) return (m_rr + k) % NUM_FSM;
        end
        return 0;
    endfunction

    function automatic bit m_bypass();
`ifdef CPU_REQ_DISPATCH_BYPASS_EN
        return (mq.size() == 0) && in_valid && (|fsm_ready);
`else
        return 1'b0;
`endif
    endfunction

    // Model state update on the active edge, using the inputs held over the cycle.
    always @(posedge clk) begin : model_update
        int g;
        bit do_push;
        if (!rst_n) begin
            mq.delete();
            m_rr = 0;
            m_on = 1'b1;
        end else if (m_on) begin
            g = m_grant();
            if (m_bypass()) begin
                m_rr = (g + 1) % NUM_FSM;
            end else begin
                do_push = in_valid && (mq.size() < DEPTH);
                if (mq.size() != 0 && (|fsm_ready)) begin
                    void'(mq.pop_front());
                    m_rr = (g + 1) % NUM_FSM;
                end
                if (do_push) mq.push_back({in_opcode, in_key_addr, in_text_addr, in_text_width});
            end
        end
    end

    // Compare the DUT with the model in the middle of every cycle.
    always @(negedge clk) begin : model_compare
        logic [NUM_FSM-1:0] exp_valid;
        logic [ENTRY_W-1:0] exp_entry;
        if (m_on) begin
            exp_valid = '0;
            exp_entry = '0;
            if (mq.size() != 0) begin
                exp_entry = mq[0];
                if (|fsm_ready) exp_valid = NUM_FSM'(1) << m_grant();
            end else if (m_bypass()) begin
                exp_entry = {in_opcode, in_key_addr, in_text_addr, in_text_width};
                exp_valid = NUM_FSM'(1) << m_grant();
            end
            check("model count", 32'(count), 32'(mq.size()));
            check("model in_ready", 32'(in_ready), 32'(mq.size() < DEPTH));
            check("model fsm_valid", 32'(fsm_valid), 32'(exp_valid));
            check("model out_bus", 32'({out_opcode, out_key_addr, out_text_addr, out_text_width}),
                  32'(exp_entry));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input int op, input int key, input int txt, input int w);
        in_valid      = v;
        in_opcode     = CPU_OPCODE_W'(op);
        in_key_addr   = ADDR_W'(key);
        in_text_addr  = ADDR_W'(txt);
        in_text_width = ADDR_W_ENCODING_W'(w);
    endtask

    initial begin
        rst_n     = 1'b0;
        fsm_ready = '0;
        drive(1'b0, 0, 0, 0, 0);
        step();
        step();
        rst_n = 1'b1;
        mid();
        check("reset count", 32'(count), 32'd0);
        check("reset in_ready", 32'(in_ready), 32'd1);
        check("reset fsm_valid", 32'(fsm_valid), 32'd0);
        step();

        // Single request, all FSMs idle.
        fsm_ready = 4'b1111;
        drive(1'b1, 2, 'h3A, 'h100, 5);
`ifdef CPU_REQ_DISPATCH_BYPASS_EN
        mid();
        check("t1 bypass fsm_valid", 32'(fsm_valid), 32'h1);
        check("t1 bypass key", 32'(out_key_addr), 32'h3A);
        step();
        in_valid = 1'b0;
`else
        step();
        in_valid = 1'b0;
        mid();
        check("t1 fsm_valid", 32'(fsm_valid), 32'h1);
        check("t1 opcode", 32'(out_opcode), 32'd2);
        check("t1 key", 32'(out_key_addr), 32'h3A);
        check("t1 text", 32'(out_text_addr), 32'h100);
        check("t1 width", 32'(out_text_width), 32'd5);
        step();
`endif
        mid();
        check("t1 drained count", 32'(count), 32'd0);
        check("t1 drained fsm_valid", 32'(fsm_valid), 32'd0);
        step();

        // Fill while blocked, drop a fifth request, then drain in order.
        rst_n = 1'b0;
        step();
        rst_n     = 1'b1;
        fsm_ready = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, i, 'h20 + i, 'h200 + i, i);
            step();
        end
        drive(1'b1, 3, 'h2F, 'h2FF, 7);
        mid();
        check("t2 full count", 32'(count), 32'd4);
        check("t2 full in_ready", 32'(in_ready), 32'd0);
        step();
        in_valid = 1'b0;
        mid();
        check("t2 drop count", 32'(count), 32'd4);
        step();
        fsm_ready = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            mid();
            check("t3 rr grant", 32'(fsm_valid), 32'(1 << i));
            check("t3 order key", 32'(out_key_addr), 32'('h20 + i));
            step();
        end
        mid();
        check("t3 empty count", 32'(count), 32'd0);
        check("t3 empty fsm_valid", 32'(fsm_valid), 32'd0);
        step();

        // Round-robin wrap-around with only FSM0/FSM1 idle.
        fsm_ready = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1, 'h40 + i, 'h140 + i, 2);
            step();
        end
        in_valid  = 1'b0;
        fsm_ready = 4'b1111;
        mid();
        check("t4 grant A", 32'(fsm_valid), 32'h1);
        step();
        mid();
        check("t4 grant B", 32'(fsm_valid), 32'h2);
        step();
        fsm_ready = 4'b0011;
        mid();
        check("t4 wrap grant", 32'(fsm_valid), 32'h1);
        check("t4 wrap key", 32'(out_key_addr), 32'h42);
        step();
        mid();
        check("t4 rr after wrap", 32'(fsm_valid), 32'h2);
        check("t4 rr key", 32'(out_key_addr), 32'h43);
        step();

        // Simultaneous push/pop at count=2 across the pointer wrap.
        fsm_ready = 4'b0000;
        drive(1'b1, 0, 'h10, 'h310, 1);
        step();
        drive(1'b1, 0, 'h11, 'h311, 1);
        step();
        fsm_ready = 4'b1111;
        for (int c = 0; c < 4; c++) begin
            drive(1'b1, 0, 'h12 + c, 'h312 + c, 1);
            mid();
            check("t5 steady count", 32'(count), 32'd2);
            check("t5 order key", 32'(out_key_addr), 32'('h10 + c));
            step();
        end
        in_valid = 1'b0;
        mid();
        check("t5 tail count", 32'(count), 32'd2);
        check("t5 tail key", 32'(out_key_addr), 32'h14);
        step();
        mid();
        check("t5 last count", 32'(count), 32'd1);
        check("t5 last key", 32'(out_key_addr), 32'h15);
        step();
        mid();
        check("t5 empty count", 32'(count), 32'd0);
        step();

        // Reset in the middle of operation discards stored entries.
        fsm_ready = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 3, 'h50 + i, 'h150 + i, 4);
            step();
        end
        in_valid = 1'b0;
        mid();
        check("t6 pre-reset count", 32'(count), 32'd3);
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        mid();
        check("t6 reset count", 32'(count), 32'd0);
        check("t6 reset fsm_valid", 32'(fsm_valid), 32'd0);
        check("t6 reset in_ready", 32'(in_ready), 32'd1);
        step();
        fsm_ready = 4'b1111;
        mid();
        check("t6 no stale dispatch", 32'(fsm_valid), 32'd0);
        step();

        // Empty queue with only FSM2 idle.
        fsm_ready = 4'b0100;
        drive(1'b1, 1, 'h77, 'h177, 3);
`ifdef CPU_REQ_DISPATCH_BYPASS_EN
        mid();
        check("t7 bypass fsm_valid", 32'(fsm_valid), 32'h4);
        check("t7 bypass key", 32'(out_key_addr), 32'h77);
        check("t7 bypass in_ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        mid();
        check("t7 bypass count", 32'(count), 32'd0);
        check("t7 bypass after fsm_valid", 32'(fsm_valid), 32'd0);
`else
        mid();
        check("t7 no same-cycle valid", 32'(fsm_valid), 32'd0);
        step();
        in_valid = 1'b0;
        mid();
        check("t7 fsm_valid", 32'(fsm_valid), 32'h4);
        check("t7 key", 32'(out_key_addr), 32'h77);
        check("t7 count", 32'(count), 32'd1);
        step();
        mid();
        check("t7 drained count", 32'(count), 32'd0);
`endif
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
